// File: rtl/cache_types_pkg.sv
// Shared types for the cache flush controller: FSM state encoding and address width.
package cache_types_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    WRITE = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } flush_state_e;

endpackage

// File: rtl/cache_flush_ctrl.sv
// Walks every set, writes back dirty lines and clears them; pulses flush_done at the end.
// One SCAN cycle per set, plus (WRITE cycles + 1) per dirty line; WRITE stalls until wb_resp.
module cache_flush_ctrl
  import cache_types_pkg::*;
#(
  parameter int s_index  = 3,
  parameter int num_sets = 2 ** s_index,
  parameter int s_offset = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush_req,
  output logic                                busy,
  output logic                                flush_done,
  output logic [s_index:0]                    flush_count,
  output logic [s_index-1:0]                  dirty_index,
  input  logic                                dirty_in,
  input  logic [ADDR_W-s_offset-s_index-1:0]  tag_in,
  output logic                                dirty_clr,
  output logic                                wb_write,
  output logic [ADDR_W-1:0]                   wb_addr,
  input  logic                                wb_resp
);

  localparam logic [s_index-1:0] LAST_IDX = s_index'(num_sets - 1);

  flush_state_e        state_q, state_d;
  logic [s_index-1:0]  idx_q, idx_d;
  logic [s_index:0]    count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          idx_d   = '0;
          count_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (dirty_in) begin
          state_d = WRITE;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      WRITE: begin
        if (wb_resp) state_d = CLEAR;
      end
      CLEAR: begin
        count_d = count_q + 1'b1;
        // The last set finishes straight from CLEAR so idx never wraps.
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = SCAN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    flush_done = (state_q == DONE);
    wb_write   = (state_q == WRITE);
    dirty_clr  = (state_q == CLEAR);
    wb_addr    = '0;
    if (state_q == WRITE) wb_addr = {tag_in, idx_q, {s_offset{1'b0}}};
  end

  assign dirty_index = idx_q;
  assign flush_count = count_q;

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Directed bench for cache_flush_ctrl: behavioural dirty/tag array and memory responder.
module tb_cache_flush_ctrl;
  import cache_types_pkg::*;

  localparam int SI = 3;
  localparam int NS = 8;
  localparam int SO = 5;
  localparam int ST = ADDR_W - SO - SI;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              flush_req = 1'b0;
  logic              busy;
  logic              flush_done;
  logic [SI:0]       flush_count;
  logic [SI-1:0]     dirty_index;
  logic              dirty_in;
  logic [ST-1:0]     tag_in;
  logic              dirty_clr;
  logic              wb_write;
  logic [31:0]       wb_addr;
  logic              wb_resp = 1'b0;

  always #5 clk = ~clk;

  cache_flush_ctrl #(.s_index(SI), .num_sets(NS), .s_offset(SO)) dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .busy(busy),
    .flush_done(flush_done), .flush_count(flush_count), .dirty_index(dirty_index),
    .dirty_in(dirty_in), .tag_in(tag_in), .dirty_clr(dirty_clr),
    .wb_write(wb_write), .wb_addr(wb_addr), .wb_resp(wb_resp)
  );

  // A line is dirty while its clear-toggle still matches the snapshot taken when it was loaded.
  logic [NS-1:0] dirty_set = '0;
  logic [NS-1:0] base_tog  = '0;
  logic [NS-1:0] clr_tog   = '0;
  logic [ST-1:0] tag_mem [NS];

  assign dirty_in = dirty_set[dirty_index] && (clr_tog[dirty_index] == base_tog[dirty_index]);
  assign tag_in   = tag_mem[dirty_index];

  int   resp_lat = 1;
  logic spurious = 1'b0;
  int   cyc = 0;

  int   wcnt = 0, wr_starts = 0, wr_cycles = 0, clr_cnt = 0, done_cnt = 0, done_cyc = 0;
  int   busy_nd = 0, unstable = 0, nonmono = 0, both_hi = 0;
  logic prev_wr = 1'b0;
  logic [31:0] last_addr = '0;
  logic [SI-1:0] prev_idx = '0;
  logic [31:0] wb_log[$];
  int          clr_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wb_write && !prev_wr) begin
      wr_starts++;
      wb_log.push_back(wb_addr);
      last_addr = wb_addr;
    end else if (wb_write && wb_addr != last_addr) begin
      unstable++;
    end
    if (wb_write) wr_cycles++;
    if (wb_write && dirty_clr) both_hi++;
    if (dirty_clr) begin
      clr_cnt++;
      clr_log.push_back(int'(dirty_index));
      clr_tog[dirty_index] = ~clr_tog[dirty_index];
    end
    if (flush_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && !flush_done) busy_nd++;
    if (busy) begin
      if (dirty_index < prev_idx) nonmono++;
      prev_idx = dirty_index;
    end else begin
      prev_idx = '0;
    end
    prev_wr = wb_write;
    if (wb_write) begin
      wcnt++;
      wb_resp = (resp_lat != 0) && (wcnt == resp_lat);
    end else begin
      wcnt    = 0;
      wb_resp = spurious;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int b_wr, b_wrc, b_clr, b_done, b_busy, b_unst, b_nonmono, b_both, b_log, b_clog, accept_cyc;

  task automatic snapshot();
    b_wr = wr_starts;  b_wrc = wr_cycles; b_clr = clr_cnt;  b_done = done_cnt;
    b_busy = busy_nd;  b_unst = unstable; b_nonmono = nonmono; b_both = both_hi;
    b_log = wb_log.size(); b_clog = clr_log.size();
  endtask

  task automatic load(input logic [NS-1:0] mask);
    dirty_set = mask;
    base_tog  = clr_tog;
  endtask

  task automatic start_flush();
    @(negedge clk); #1;
    flush_req = 1'b1;
    @(posedge clk); #1;
    accept_cyc = cyc;
    flush_req  = 1'b0;
  endtask

  task automatic run_check(input string n, input int lat, input int wr, input int cnt);
    int k = 0;
    while (done_cnt == b_done && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    chk({n, " done pulses"}, done_cnt - b_done, 1);
    chk({n, " latency"}, done_cyc - accept_cyc, lat);
    chk({n, " writebacks"}, wr_starts - b_wr, wr);
    chk({n, " clears"}, clr_cnt - b_clr, wr);
    chk({n, " flush_count"}, 32'(flush_count), cnt);
    chk({n, " addr unstable"}, unstable - b_unst, 0);
    chk({n, " idx wrap"}, nonmono - b_nonmono, 0);
    chk({n, " wr+clr overlap"}, both_hi - b_both, 0);
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NS; i++) tag_mem[i] = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst busy", 32'(busy), 0);
    chk("rst flush_done", 32'(flush_done), 0);
    chk("rst dirty_clr", 32'(dirty_clr), 0);
    chk("rst wb_write", 32'(wb_write), 0);
    chk("rst wb_addr", wb_addr, 0);
    chk("rst dirty_index", 32'(dirty_index), 0);
    chk("rst flush_count", 32'(flush_count), 0);
    @(negedge clk); #1 rst_n = 1'b1;

    // All sets clean.
    load('0); resp_lat = 1; snapshot();
    start_flush();
    run_check("clean", 8, 0, 0);
    chk("clean scan cycles", busy_nd - b_busy, 8);

    // Set 3 dirty, memory answers in the fourth WRITE cycle.
    tag_mem[3] = 24'h012345; load(8'b0000_1000); resp_lat = 4; snapshot();
    start_flush();
    run_check("set3", 13, 1, 1);
    chk("set3 addr", wb_log[b_log], 32'h0123_4560);
    chk("set3 write cycles", wr_cycles - b_wrc, 4);
    chk("set3 clr idx", clr_log[b_clog], 3);
    repeat (5) @(negedge clk);
    #1 chk("set3 count hold", 32'(flush_count), 1);

    // Only the last set dirty.
    tag_mem[7] = 24'h000001; load(8'b1000_0000); resp_lat = 1; snapshot();
    start_flush();
    run_check("set7", 10, 1, 1);
    chk("set7 addr", wb_log[b_log], 32'h0000_01E0);
    chk("set7 clr idx", clr_log[b_clog], 7);

    // Every set dirty.
    for (int i = 0; i < NS; i++) tag_mem[i] = 24'hC0FFE0 + 24'(i);
    load(8'hFF); resp_lat = 1; snapshot();
    start_flush();
    run_check("all", 24, 8, 8);
    for (int i = 0; i < NS; i++) begin
      chk($sformatf("all addr%0d", i), wb_log[b_log + i], 32'hC0FF_E000 + 32'(i) * 32'h120);
      chk($sformatf("all clr%0d", i), clr_log[b_clog + i], i);
    end

    // Reset while a writeback is outstanding.
    tag_mem[5] = 24'hABCDEF; load(8'b0010_0000); resp_lat = 0; snapshot();
    start_flush();
    for (int k = 0; k < 40 && !wb_write; k++) begin
      @(negedge clk); #1;
    end
    chk("rstw reached write", 32'(wb_write), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw wb_write", 32'(wb_write), 0);
    chk("rstw busy", 32'(busy), 0);
    chk("rstw dirty_clr", 32'(dirty_clr), 0);
    chk("rstw wb_addr", wb_addr, 0);
    chk("rstw flush_count", 32'(flush_count), 0);
    chk("rstw clears", clr_cnt - b_clr, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    snapshot();
    repeat (6) @(negedge clk);
    #1;
    chk("rstw idle busy", busy_nd - b_busy, 0);
    chk("rstw idle writes", wr_starts - b_wr, 0);
    resp_lat = 2; snapshot();
    start_flush();
    run_check("rewrite", 11, 1, 1);
    chk("rewrite addr", wb_log[b_log], 32'hABCD_EFA0);

    // Flush request while busy and wb_resp outside WRITE are both ignored.
    tag_mem[2] = 24'h7FFFFF; load(8'b0000_0100); resp_lat = 3; spurious = 1'b1; snapshot();
    start_flush();
    repeat (3) @(negedge clk);
    #1 flush_req = 1'b1;
    @(negedge clk); #1 flush_req = 1'b0;
    run_check("ignore", 12, 1, 1);
    chk("ignore addr", wb_log[b_log], 32'h7FFF_FF40);
    chk("ignore write cycles", wr_cycles - b_wrc, 3);
    repeat (4) @(negedge clk);
    #1 chk("ignore not queued", 32'(busy), 0);
    spurious = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
